cam_mgr: RTL and testbench
==========================

# cam_mgr

Sequencing controller for one CAM array of CAM_DEPTH entries × CAM_WIDTH bits. It accepts single-outstanding SEARCH / INSERT / DELETE / FLUSH requests over a valid/ready handshake and owns the CAM's shared write/search bus. It allocates free slots, suppresses duplicate keys and tracks occupancy. It sits between the host command path and the CAM, and the CAM's match line feeds back into it combinationally.

## Interface
Parameters:
- CAM_WIDTH, 32, key width
- CAM_DEPTH, 16, entry count (≥2, power of two)
- IW (localparam), $clog2(CAM_DEPTH), index width

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_op  in  2  0 SEARCH, 1 INSERT, 2 DELETE, 3 FLUSH
- req_key  in  CAM_WIDTH  key (ignored for FLUSH)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_status  out  2  0 OK, 1 MISS, 2 DUP, 3 FULL
- resp_idx  out  IW  entry index (matched / allocated / deleted; 0 when not applicable)
- cam_we  out  1  CAM write strobe
- cam_idx  out  IW  CAM write index
- cam_data  out  CAM_WIDTH  CAM key bus (write data and search key)
- cam_vld  out  1  valid bit written with cam_we
- cam_ml  in  CAM_DEPTH  CAM match line, combinational from cam_data
- count  out  IW+1  occupied entries
- full, empty  out  1  count==CAM_DEPTH / count==0

## Operation
- States: INIT, IDLE, LOOKUP, WRITE, FLUSH, RESP.
- Reset values:
  - state=INIT, req_ready=0, resp_valid=0.
  - cam_we=0, cam_idx=0, cam_data=0, cam_vld=0.
  - resp_status=0, resp_idx=0.
  - count=0, empty=1, full=0.
  - Shadow valid bitmap vmap=0, sweep counter=0.
- INIT: sweep idx 0..CAM_DEPTH-1, one per cycle, cam_we=1, cam_vld=0. After the last index → IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, register op and key. FLUSH → FLUSH; all other ops → LOOKUP.
- LOOKUP: cam_data=key, cam_we=0. Sample cam_ml.
  - hit = |cam_ml; hidx = lowest set bit of cam_ml.
  - fidx = lowest clear bit of vmap.
- Decision from the LOOKUP sample:
  - SEARCH: hit → OK, resp_idx=hidx; miss → MISS, resp_idx=0.
  - INSERT:
    - hit → DUP, resp_idx=hidx, no write.
    - miss & full → FULL, resp_idx=0.
    - miss & !full → WRITE at fidx with cam_vld=1. vmap[fidx]←1, count+1. Then OK, resp_idx=fidx.
  - DELETE:
    - hit → WRITE at hidx with cam_vld=0. vmap[hidx]←0, count−1. Then OK, resp_idx=hidx.
    - miss → MISS.
- WRITE: one cycle. cam_we=1, cam_data=key, cam_idx and cam_vld as above → RESP.
- FLUSH: same sweep as INIT. Then vmap=0, count=0 → RESP, status OK, resp_idx=0.
- RESP: resp_valid=1 with status and idx held stable until resp_ready. Then → IDLE.
- cam_we is 0 in all states except INIT, WRITE and FLUSH.

## Timing
- All outputs are registered except cam_data, which is valid from the LOOKUP cycle onward.
- Accept edge is T:
  - SEARCH, DUP, FULL, MISS: resp_valid at T+2.
  - INSERT-OK, DELETE-OK: cam_we at T+2, resp_valid at T+3.
  - FLUSH: writes at cycles T+1..T+CAM_DEPTH, resp_valid at T+CAM_DEPTH+1.
- After rst_n deasserts, req_ready first rises CAM_DEPTH+1 cycles later.
- One request in flight. The next accept is at the earliest one cycle after the resp handshake cycle (IDLE re-entered).
- resp_ready held high in RESP: exactly one response cycle.
- count updates on the WRITE edge; full and empty derive from the registered count.
- Boundaries:
  - A DELETE on a full CAM, then an INSERT, reuses the freed index.
  - fidx wraps to the lowest free index, with no round-robin.
  - Two matching entries cannot occur. A sim assertion checks cam_ml ⊆ vmap and $onehot0(cam_ml).
- rst_n asserted mid-operation: immediate return to reset values, the in-flight request is dropped, and INIT re-runs.

## Structure
- Package cam_mgr_pkg holds:
  - op_e {OP_SEARCH, OP_INSERT, OP_DELETE, OP_FLUSH}
  - status_e {ST_OK, ST_MISS, ST_DUP, ST_FULL}
  - state_e
- Sub-module cam_lsb_enc #(WIDTH): combinational lowest-set-bit encoder with output idx and any. It is instantiated twice: on cam_ml and on ~vmap.
- The bench uses the existing CAM model for cam_ml.

## Test plan
- Reset release: req_ready=0 for 16 cycles with cam_we=1, idx 0..15, vld=0; then req_ready=1, empty=1.
- INSERT 0xDEADBEEF then INSERT 0xCAFEF00D → OK idx 0, OK idx 1, count=2. Re-INSERT 0xDEADBEEF → DUP idx 0, count unchanged.
- SEARCH 0xCAFEF00D → OK idx 1 at T+2. SEARCH 0x12345678 → MISS idx 0.
- Fill 16 distinct keys → full=1; 17th INSERT → FULL. DELETE key at idx 5 → OK idx 5. New INSERT → OK idx 5, full=1.
- DELETE a missing key → MISS, no cam_we. FLUSH → 16 invalidating writes, OK, count=0. SEARCH a prior key → MISS.
- resp_ready low for 4 cycles in RESP: outputs stable, req_ready=0. Then rst_n pulsed during a FLUSH: outputs at reset values, INIT re-runs.

Source files
------------

// File: rtl/cam_mgr_pkg.sv
// ============================================================================
// Module   : cam_mgr_pkg
// Brief    : Shared opcode, status and FSM state encodings for cam_mgr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_mgr_pkg;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_FLUSH  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_MISS = 2'd1,
        ST_DUP  = 2'd2,
        ST_FULL = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_WRITE  = 3'd3,
        S_FLUSH  = 3'd4,
        S_RESP   = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cam_lsb_enc.sv
// ============================================================================
// Module   : cam_lsb_enc
// Brief    : Combinational lowest-set-bit encoder with an any-set flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_lsb_enc #(
    parameter int WIDTH = 16,
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Scan downward so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cam_mgr.sv
// ============================================================================
// Module   : cam_mgr
// Brief    : Single-outstanding SEARCH/INSERT/DELETE/FLUSH sequencer for a CAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_mgr
    import cam_mgr_pkg::*;
#(
    parameter int CAM_WIDTH = 32,
    parameter int CAM_DEPTH = 16,
    localparam int IW       = $clog2(CAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [CAM_WIDTH-1:0] req_key,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [1:0]           resp_status,
    output logic [IW-1:0]        resp_idx,
    output logic                 cam_we,
    output logic [IW-1:0]        cam_idx,
    output logic [CAM_WIDTH-1:0] cam_data,
    output logic                 cam_vld,
    input  logic [CAM_DEPTH-1:0] cam_ml,
    output logic [IW:0]          count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [IW:0] c_DEPTH = CAM_DEPTH[IW:0];

    state_e                 r_state;
    op_e                    r_op;
    logic [CAM_WIDTH-1:0]   r_key;
    logic [CAM_DEPTH-1:0]   r_vmap;
    logic [IW:0]            r_sweep;
    logic                   r_phase;
    logic                   r_hit;
    logic                   r_free;
    logic [IW-1:0]          r_hidx;
    logic [IW-1:0]          r_fidx;

    logic [IW-1:0]          w_hidx;
    logic [IW-1:0]          w_fidx;
    logic                   w_hit;
    logic                   w_fany;

    cam_lsb_enc #(.WIDTH(CAM_DEPTH)) u_hit_enc (
        .vec (cam_ml),
        .idx (w_hidx),
        .any (w_hit)
    );

    cam_lsb_enc #(.WIDTH(CAM_DEPTH)) u_free_enc (
        .vec (~r_vmap),
        .idx (w_fidx),
        .any (w_fany)
    );

    assign cam_data = r_key;
    assign full     = (count == c_DEPTH);
    assign empty    = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_op        <= OP_SEARCH;
            r_key       <= '0;
            r_vmap      <= '0;
            r_sweep     <= '0;
            r_phase     <= 1'b0;
            r_hit       <= 1'b0;
            r_free      <= 1'b0;
            r_hidx      <= '0;
            r_fidx      <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_status <= ST_OK;
            resp_idx    <= '0;
            cam_we      <= 1'b0;
            cam_idx     <= '0;
            cam_vld     <= 1'b0;
            count       <= '0;
        end else begin
            cam_we <= 1'b0;
            case (r_state)
                S_INIT, S_FLUSH: begin
                    if (r_sweep == c_DEPTH) begin
                        if (r_state == S_INIT) begin
                            req_ready <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_vmap      <= '0;
                            count       <= '0;
                            resp_status <= ST_OK;
                            resp_idx    <= '0;
                            resp_valid  <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else begin
                        cam_we  <= 1'b1;
                        cam_vld <= 1'b0;
                        cam_idx <= r_sweep[IW-1:0];
                        r_sweep <= r_sweep + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_op      <= op_e'(req_op);
                        r_key     <= req_key;
                        r_phase   <= 1'b0;
                        r_sweep   <= '0;
                        r_state   <= (req_op == OP_FLUSH) ? S_FLUSH : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // First cycle registers the match/free encodings; second acts on them.
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_hit   <= w_hit;
                        r_hidx  <= w_hidx;
                        r_fidx  <= w_fidx;
                        r_free  <= w_fany;
                    end else begin
                        resp_idx   <= '0;
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                        case (r_op)
                            OP_SEARCH: begin
                                resp_status <= r_hit ? ST_OK : ST_MISS;
                                resp_idx    <= r_hit ? r_hidx : '0;
                            end
                            OP_INSERT: begin
                                if (r_hit) begin
                                    resp_status <= ST_DUP;
                                    resp_idx    <= r_hidx;
                                end else if (!r_free) begin
                                    resp_status <= ST_FULL;
                                end else begin
                                    resp_valid <= 1'b0;
                                    cam_we     <= 1'b1;
                                    cam_idx    <= r_fidx;
                                    cam_vld    <= 1'b1;
                                    r_state    <= S_WRITE;
                                end
                            end
                            OP_DELETE: begin
                                if (r_hit) begin
                                    resp_valid <= 1'b0;
                                    cam_we     <= 1'b1;
                                    cam_idx    <= r_hidx;
                                    cam_vld    <= 1'b0;
                                    r_state    <= S_WRITE;
                                end else begin
                                    resp_status <= ST_MISS;
                                end
                            end
                            default: resp_status <= ST_OK;
                        endcase
                    end
                end
                S_WRITE: begin
                    r_vmap[cam_idx] <= cam_vld;
                    count           <= cam_vld ? count + 1'b1 : count - 1'b1;
                    resp_status     <= ST_OK;
                    resp_idx        <= cam_idx;
                    resp_valid      <= 1'b1;
                    r_state         <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ml_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_LOOKUP) |-> (((cam_ml & ~r_vmap) == '0) && $onehot0(cam_ml)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_cam_mgr.sv
// ============================================================================
// Module   : tb_cam_mgr
// Brief    : Directed, table-driven bench for cam_mgr with a behavioural CAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_mgr;

    localparam int W = 32;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [W-1:0]  req_key;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_status;
    logic [3:0]    resp_idx;
    logic          cam_we;
    logic [3:0]    cam_idx;
    logic [W-1:0]  cam_data;
    logic          cam_vld;
    logic [D-1:0]  cam_ml;
    logic [4:0]    count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    cam_mgr #(.CAM_WIDTH(W), .CAM_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_key     (req_key),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_idx    (resp_idx),
        .cam_we      (cam_we),
        .cam_idx     (cam_idx),
        .cam_data    (cam_data),
        .cam_vld     (cam_vld),
        .cam_ml      (cam_ml),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // Behavioural CAM array: write on cam_we, combinational match on valid entries.
    logic [W-1:0] cam_key [D];
    logic [D-1:0] cam_valid = '0;

    always @(posedge clk) begin
        if (cam_we) begin
            cam_key[cam_idx]   <= cam_data;
            cam_valid[cam_idx] <= cam_vld;
        end
    end

    always_comb begin
        cam_ml = '0;
        for (int i = 0; i < D; i++)
            cam_ml[i] = cam_valid[i] && (cam_key[i] == cam_data);
    end

    int we_cnt = 0;
    always @(negedge clk) begin
        if (cam_we) we_cnt <= we_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] key;
        logic [1:0]  st;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        int          lat;
        int          wr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mkv(logic [1:0] op, logic [31:0] key, logic [1:0] st,
                                 logic [3:0] idx, logic [4:0] cnt, int lat, int wr);
        vec_t v;
        v.op = op; v.key = key; v.st = st; v.idx = idx; v.cnt = cnt; v.lat = lat; v.wr = wr;
        return v;
    endfunction

    task automatic check_init();
        for (int k = 0; k < D; k++) begin
            @(posedge clk); #1;
            chk($sformatf("init_we[%0d]", k),  cam_we, 1);
            chk($sformatf("init_idx[%0d]", k), cam_idx, k);
            chk($sformatf("init_vld[%0d]", k), cam_vld, 0);
            chk($sformatf("init_rdy[%0d]", k), req_ready, 0);
        end
        @(posedge clk); #1;
        chk("init_done_ready", req_ready, 1);
        chk("init_done_empty", empty, 1);
        chk("init_done_count", count, 0);
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk({name, "_ready_timeout"}, req_ready, 1);
    endtask

    // One full request/response transaction with resp_ready held high.
    task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] key,
                          output logic [1:0] st, output logic [3:0] idx,
                          output int lat, output int wr);
        int t0;
        wait_ready(name);
        t0        = we_cnt;
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        st  = resp_status;
        idx = resp_idx;
        @(posedge clk); #1;
        wr  = we_cnt - t0;
    endtask

    initial begin
        logic [1:0] st;
        logic [3:0] idx;
        int         lat;
        int         wr;
        int         w;
        logic [1:0] st0;
        logic [3:0] idx0;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_key    = '0;
        resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",  req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_cam_we",     cam_we, 0);
        chk("rst_cam_data",   cam_data, 0);
        chk("rst_count",      count, 0);
        chk("rst_empty",      empty, 1);
        chk("rst_full",       full, 0);

        @(posedge clk); #3;
        rst_n = 1'b1;
        check_init();

        tv.push_back(mkv(2'd1, 32'hDEADBEEF, 2'd0, 4'd0, 5'd1, 3, 1));
        tv.push_back(mkv(2'd1, 32'hCAFEF00D, 2'd0, 4'd1, 5'd2, 3, 1));
        tv.push_back(mkv(2'd1, 32'hDEADBEEF, 2'd2, 4'd0, 5'd2, 2, 0));
        tv.push_back(mkv(2'd0, 32'hCAFEF00D, 2'd0, 4'd1, 5'd2, 2, 0));
        tv.push_back(mkv(2'd0, 32'h12345678, 2'd1, 4'd0, 5'd2, 2, 0));
        for (int i = 2; i < D; i++)
            tv.push_back(mkv(2'd1, 32'h1000_0000 + i, 2'd0, 4'(i), 5'(i + 1), 3, 1));
        tv.push_back(mkv(2'd1, 32'h55555555, 2'd3, 4'd0, 5'd16, 2, 0));
        tv.push_back(mkv(2'd2, 32'h10000005, 2'd0, 4'd5, 5'd15, 3, 1));
        tv.push_back(mkv(2'd1, 32'h66666666, 2'd0, 4'd5, 5'd16, 3, 1));
        tv.push_back(mkv(2'd2, 32'h77777777, 2'd1, 4'd0, 5'd16, 2, 0));
        tv.push_back(mkv(2'd3, 32'h00000000, 2'd0, 4'd0, 5'd0, 17, 16));
        tv.push_back(mkv(2'd0, 32'hCAFEF00D, 2'd1, 4'd0, 5'd0, 2, 0));
        tv.push_back(mkv(2'd1, 32'hA5A5A5A5, 2'd0, 4'd0, 5'd1, 3, 1));

        foreach (tv[n]) begin
            do_req($sformatf("v%0d", n), tv[n].op, tv[n].key, st, idx, lat, wr);
            chk($sformatf("v%0d_status", n), st, tv[n].st);
            chk($sformatf("v%0d_idx", n), idx, tv[n].idx);
            chk($sformatf("v%0d_latency", n), lat, tv[n].lat);
            chk($sformatf("v%0d_writes", n), wr, tv[n].wr);
            chk($sformatf("v%0d_count", n), count, tv[n].cnt);
            chk($sformatf("v%0d_full", n), full, tv[n].cnt == 5'd16);
            chk($sformatf("v%0d_empty", n), empty, tv[n].cnt == 5'd0);
            chk($sformatf("v%0d_resp_done", n), resp_valid, 0);
        end

        // Response back-pressure: held stable for four cycles.
        wait_ready("stall");
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_op     = 2'd0;
        req_key    = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!resp_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("stall_latency", w, 2);
        st0  = resp_status;
        idx0 = resp_idx;
        chk("stall_status", st0, 2'd0);
        chk("stall_idx", idx0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_valid[%0d]", k), resp_valid, 1);
            chk($sformatf("stall_status[%0d]", k), resp_status, st0);
            chk($sformatf("stall_idx[%0d]", k), resp_idx, idx0);
            chk($sformatf("stall_rdy[%0d]", k), req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", resp_valid, 0);
        chk("stall_release_ready", req_ready, 1);

        // Reset in the middle of a FLUSH drops it and reruns INIT.
        wait_ready("flush_rst");
        req_valid = 1'b1;
        req_op    = 2'd3;
        req_key   = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_mid_we", cam_we, 1);
        chk("flush_mid_count", count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cam_we", cam_we, 0);
        chk("midrst_cam_idx", cam_idx, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        check_init();
        do_req("post_rst", 2'd0, 32'hA5A5A5A5, st, idx, lat, wr);
        chk("post_rst_status", st, 2'd1);
        chk("post_rst_idx", idx, 4'd0);
        chk("post_rst_latency", lat, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
